// File: rtl/dram_cycle_seq.sv
// DRAM bus-cycle sequencer: 16-clk32 cycles alternating video/CPU slots with RAS/CAS timing.
// Optional macro REFRESH_EN builds the refresh counter, pending flag and CBR refresh cycles.
module dram_cycle_seq #(
    parameter int ADDR_W      = 20,
    parameter int REFRESH_DIV = 64
) (
    input  logic                clk32,
    input  logic                resb,
    input  logic                mhz8_en,
    input  logic                cycsel_en,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic [ADDR_W/2-1:0] ram_a,
    output logic                ras_n,
    output logic                cas_n,
    output logic                ram_we_n,
    output logic                latch,
    output logic                cpu_ack,
    output logic                vid_ack,
    output logic                refreshing
);
    localparam int HALF_W = ADDR_W / 2;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_REF  = 2'd3
    } owner_t;

    owner_t              owner_r, owner_s;
    logic [1:0]          ph_r, ph_s;
    logic                slot_r, slot_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic                we_r, we_s;
    logic [HALF_W-1:0]   ram_a_r, ram_a_s;
    logic                ras_n_r, ras_n_s, cas_n_r, cas_n_s, ram_we_n_r, ram_we_n_s;
    logic                latch_r, latch_s, cpu_ack_r, cpu_ack_s, vid_ack_r, vid_ack_s;
    logic                refr_r, refr_s;
    logic                pending_s;

    // Next-state and next-output values; only mhz8_en edges move the sequencer.
    always_comb begin
        owner_s    = owner_r;
        ph_s       = ph_r;
        slot_s     = slot_r;
        addr_s     = addr_r;
        we_s       = we_r;
        ram_a_s    = ram_a_r;
        ras_n_s    = ras_n_r;
        cas_n_s    = cas_n_r;
        ram_we_n_s = ram_we_n_r;
        refr_s     = refr_r;
        latch_s    = 1'b0;
        cpu_ack_s  = 1'b0;
        vid_ack_s  = 1'b0;
        if (mhz8_en && cycsel_en) begin
            // Close whatever was running (complete or aborted) and grant the new slot.
            ph_s       = 2'd0;
            slot_s     = ~slot_r;
            ras_n_s    = 1'b1;
            cas_n_s    = 1'b1;
            ram_we_n_s = 1'b1;
            refr_s     = 1'b0;
            if (!slot_r && vid_req) begin
                owner_s = OWN_VID;
                addr_s  = vid_addr;
                we_s    = 1'b0;
            end else if (slot_r && cpu_req) begin
                owner_s = OWN_CPU;
                addr_s  = cpu_addr;
                we_s    = cpu_we;
            end else if (pending_s) begin
                owner_s = OWN_REF;
                refr_s  = 1'b1;
            end else begin
                owner_s = OWN_IDLE;
            end
            if (owner_s == OWN_VID || owner_s == OWN_CPU) begin
                ram_a_s = addr_s[ADDR_W-1:HALF_W];
            end else begin
                ram_a_s = ram_a_r;
            end
        end else if (mhz8_en && ph_r != 2'd3) begin
            ph_s = ph_r + 2'd1;
            case (owner_r)
                OWN_VID, OWN_CPU: begin
                    case (ph_s)
                        2'd1: ras_n_s = 1'b0;
                        2'd2: begin
                            ram_a_s    = addr_r[HALF_W-1:0];
                            cas_n_s    = 1'b0;
                            ram_we_n_s = ~we_r;
                        end
                        2'd3: begin
                            latch_s   = ~we_r;
                            cpu_ack_s = (owner_r == OWN_CPU);
                            vid_ack_s = (owner_r == OWN_VID);
                        end
                        default: begin end
                    endcase
                end
                OWN_REF: begin
                    // CAS-before-RAS
                    case (ph_s)
                        2'd1:    cas_n_s = 1'b0;
                        2'd2:    ras_n_s = 1'b0;
                        default: begin end
                    endcase
                end
                default: begin end
            endcase
        end else begin
            ph_s = ph_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk32) begin
        if (!resb) begin
            owner_r    <= OWN_IDLE;
            ph_r       <= 2'd0;
            slot_r     <= 1'b0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            ram_a_r    <= '0;
            ras_n_r    <= 1'b1;
            cas_n_r    <= 1'b1;
            ram_we_n_r <= 1'b1;
            latch_r    <= 1'b0;
            cpu_ack_r  <= 1'b0;
            vid_ack_r  <= 1'b0;
            refr_r     <= 1'b0;
        end else begin
            owner_r    <= owner_s;
            ph_r       <= ph_s;
            slot_r     <= slot_s;
            addr_r     <= addr_s;
            we_r       <= we_s;
            ram_a_r    <= ram_a_s;
            ras_n_r    <= ras_n_s;
            cas_n_r    <= cas_n_s;
            ram_we_n_r <= ram_we_n_s;
            latch_r    <= latch_s;
            cpu_ack_r  <= cpu_ack_s;
            vid_ack_r  <= vid_ack_s;
            refr_r     <= refr_s;
        end
    end

`ifdef REFRESH_EN
    localparam int CNT_W = $clog2(REFRESH_DIV);
    logic [CNT_W-1:0] ref_cnt_r;
    logic             pending_r;

    // Refresh interval counter; an aborted REF cycle re-arms its request.
    always_ff @(posedge clk32) begin
        if (!resb) begin
            ref_cnt_r <= '0;
            pending_r <= 1'b0;
        end else if (mhz8_en && cycsel_en) begin
            if (ref_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
                ref_cnt_r <= '0;
                pending_r <= 1'b1;
            end else begin
                ref_cnt_r <= ref_cnt_r + CNT_W'(1);
                if (owner_r == OWN_REF && ph_r != 2'd3) begin
                    pending_r <= 1'b1;
                end else if (owner_s == OWN_REF) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
            end
        end else begin
            ref_cnt_r <= ref_cnt_r;
            pending_r <= pending_r;
        end
    end

    assign pending_s = pending_r;
`else
    assign pending_s = 1'b0;
`endif

    assign ram_a      = ram_a_r;
    assign ras_n      = ras_n_r;
    assign cas_n      = cas_n_r;
    assign ram_we_n   = ram_we_n_r;
    assign latch      = latch_r;
    assign cpu_ack    = cpu_ack_r;
    assign vid_ack    = vid_ack_r;
    assign refreshing = refr_r;
endmodule
